lv_owt_tx_arb: RTL and testbench
================================

# lv_owt_tx_arb

Shares the single low-voltage one-wire (OWT) transmitter among REQ_NUM frame requesters: watchdog refresh/ADC request, FSM-launched frames and SPI-forwarded commands. It grants one requester at a time, hands its payload to the OWT TX engine over a valid/ready handshake, waits for frame completion with a busy timeout, then enforces an inter-frame gap before the next grant. Requester 0 has strict priority; requesters 1..REQ_NUM-1 are served round-robin.

## Interface

- REQ_NUM, 3, number of requesters (≥2); index 0 is urgent.
- TX_DW, 16, frame payload width.
- TMO_W, 10, timeout counter width.
- TMO_TH, 1000, cycles allowed from accept to i_tx_done (≥2, < 2^TMO_W).
- GAP_CYC, 4, idle cycles between frames (≥1, < 2^TMO_W).

- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_arb_en  in  1  arbiter enable; low = flush.
- i_req  in  REQ_NUM  level requests, held until matching o_ack.
- i_req_data  in  REQ_NUM*TX_DW  payload; slice k belongs to requester k.
- o_ack  out  REQ_NUM  one-cycle completion pulse to the granted requester.
- o_tx_vld  out  1  frame valid to OWT TX.
- i_tx_rdy  in  1  OWT TX accepts frame.
- o_tx_data  out  TX_DW  latched payload of granted requester.
- i_tx_done  in  1  one-cycle pulse, frame finished on wire.
- o_tmo_err  out  1  one-cycle pulse, i_tx_done missing.
- o_grant_id  out  $clog2(REQ_NUM)  index of current or last grant.
- o_busy  out  1  state ≠ IDLE.

## Operation

- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: if i_arb_en and any i_req, select the winner, latch its index into o_grant_id and its slice into o_tx_data, then go to ISSUE. Winner selection:
  - i_req[0] set: requester 0 wins.
  - Otherwise: first set request among 1..REQ_NUM-1, searching from rr_ptr upward with wrap.
- ISSUE: o_tx_vld=1, o_tx_data stable. On o_tx_vld & i_tx_rdy, go to WAIT_DONE and clear the counter.
- WAIT_DONE: the counter increments each cycle.
  - i_tx_done: pulse o_ack[grant] and go to GAP.
  - Counter == TMO_TH-1 without done: pulse o_tmo_err and o_ack[grant] together, then go to GAP.
  - Done and timeout in the same cycle: done wins, no o_tmo_err.
- GAP: count GAP_CYC cycles, then go to IDLE.
- rr_ptr (range 1..REQ_NUM-1, reset 1) moves to grant+1 (wrapping to 1) when a grant to a requester ≥1 is acked. A grant to requester 0 leaves rr_ptr unchanged.
- A requester dropping i_req after grant does not cancel the frame; it still gets o_ack.
- i_arb_en low in any state: next cycle state=IDLE, o_tx_vld=0, counters cleared, no o_ack, no o_tmo_err. o_grant_id and o_tx_data hold. rr_ptr unchanged.
- i_tx_done outside WAIT_DONE is ignored.

## Timing

- Reset values:
  - o_ack=0, o_tx_vld=0, o_tx_data=0, o_tmo_err=0, o_grant_id=0, o_busy=0.
  - state=IDLE, rr_ptr=1, counters=0.
- All outputs are registered.
- Request sampled in IDLE at cycle T → o_tx_vld=1 and o_busy=1 at T+1.
- Accept at handshake cycle A → o_tx_vld=0 at A+1.
- i_tx_done at cycle D → o_ack pulse at D+1, GAP entered at D+1.
- Timeout: acceptance at A, i_tx_done never arrives → o_tmo_err and o_ack at A+TMO_TH+1.
- GAP occupies GAP_CYC cycles from ack. The requester drops i_req the cycle after o_ack, so the next IDLE never regrants a stale request.
- Minimum grant-to-grant spacing: 1 (ISSUE) + 1 (WAIT_DONE) + GAP_CYC + 1 (IDLE) cycles.
- o_ack is never asserted for more than one bit or for more than one cycle per grant.

## Test plan

- **Single request.** i_req=3'b010, data1=16'hA5C3, i_tx_rdy=1, i_tx_done 5 cycles after accept → o_tx_vld at T+1 with o_tx_data=16'hA5C3, o_grant_id=1, o_ack=3'b010 one cycle, then o_busy=0 after 4 GAP cycles.
- **Priority and round-robin.** i_req=3'b111 held, each requester drops on its ack → grant order 0,1,2. Then i_req=3'b110 repeated twice → 1,2,1,2.
- **Backpressure.** i_tx_rdy low 7 cycles → o_tx_vld held high with o_tx_data stable; accept on the 8th cycle.
- **Timeout.** TMO_TH=20, no i_tx_done → o_tmo_err and o_ack[grant] at accept+21. Variant: i_tx_done in the same cycle the counter reaches 19 → ack only, no error.
- **Flush.** i_arb_en dropped in WAIT_DONE → IDLE next cycle, no ack, no err. A late i_tx_done is ignored. Re-enable with the request still held → re-grant to the same requester.
- **Reset mid-frame.** i_rst_n asserted in ISSUE → all outputs 0 immediately, rr_ptr=1.

Source files
------------

// File: rtl/lv_owt_tx_arb.sv
// lv_owt_tx_arb: shares the single OWT transmitter among frame requesters.
// Requester 0 has strict priority; the rest are served round-robin.
module lv_owt_tx_arb #(
    parameter int REQ_NUM = 3,
    parameter int TX_DW   = 16,
    parameter int TMO_W   = 10,
    parameter int TMO_TH  = 1000,
    parameter int GAP_CYC = 4,
    localparam int GW     = $clog2(REQ_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_arb_en,
    input  logic [REQ_NUM-1:0]       i_req,
    input  logic [REQ_NUM*TX_DW-1:0] i_req_data,
    output logic [REQ_NUM-1:0]       o_ack,
    output logic                     o_tx_vld,
    input  logic                     i_tx_rdy,
    output logic [TX_DW-1:0]         o_tx_data,
    input  logic                     i_tx_done,
    output logic                     o_tmo_err,
    output logic [GW-1:0]            o_grant_id,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_TH - 1);
    localparam logic [TMO_W-1:0] GAP_LAST = TMO_W'(GAP_CYC - 1);
    localparam logic [GW-1:0]    ID_LAST  = GW'(REQ_NUM - 1);
    localparam logic [GW-1:0]    ID_ONE   = GW'(1);

    state_t               state;
    state_t               state_nxt;
    logic [TMO_W-1:0]     cnt;
    logic [TMO_W-1:0]     cnt_nxt;
    logic [GW-1:0]        rr_ptr;
    logic [GW-1:0]        rr_nxt;
    logic [REQ_NUM-1:0]   ack_nxt;
    logic                 err_nxt;
    logic [GW-1:0]        gid_nxt;
    logic [TX_DW-1:0]     data_nxt;
    logic                 win_vld;
    logic [GW-1:0]        win_id;
    int                   idx;

    // Winner: requester 0 first, else first request at or after rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        if (i_req[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int i = 0; i < REQ_NUM - 1; i++) begin
                idx = ((int'(rr_ptr) - 1 + i) % (REQ_NUM - 1)) + 1;
                if (!win_vld && i_req[idx]) begin
                    win_vld = 1'b1;
                    win_id  = GW'(idx);
                end
            end
        end
    end

    // Next state, counter, and the next value of every registered output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        gid_nxt   = o_grant_id;
        data_nxt  = o_tx_data;
        rr_nxt    = rr_ptr;
        unique case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    state_nxt = ST_ISSUE;
                    gid_nxt   = win_id;
                    data_nxt  = i_req_data[win_id*TX_DW +: TX_DW];
                end
            end
            ST_ISSUE: begin
                if (i_tx_rdy) begin
                    state_nxt = ST_WAIT_DONE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_DONE: begin
                cnt_nxt = cnt + TMO_W'(1);
                if (i_tx_done || cnt == TMO_LAST) begin
                    state_nxt           = ST_GAP;
                    cnt_nxt             = '0;
                    ack_nxt[o_grant_id] = 1'b1;
                    err_nxt             = !i_tx_done;
                    if (o_grant_id != '0) begin
                        rr_nxt = (o_grant_id == ID_LAST) ? ID_ONE
                                                         : o_grant_id + ID_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + TMO_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (!i_arb_en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            ack_nxt   = '0;
            err_nxt   = 1'b0;
            gid_nxt   = o_grant_id;
            data_nxt  = o_tx_data;
            rr_nxt    = rr_ptr;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rr_ptr     <= ID_ONE;
            o_ack      <= '0;
            o_tmo_err  <= 1'b0;
            o_grant_id <= '0;
            o_tx_data  <= '0;
            o_tx_vld   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rr_ptr     <= rr_nxt;
            o_ack      <= ack_nxt;
            o_tmo_err  <= err_nxt;
            o_grant_id <= gid_nxt;
            o_tx_data  <= data_nxt;
            o_tx_vld   <= (state_nxt == ST_ISSUE);
            o_busy     <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_lv_owt_tx_arb.sv
// tb_lv_owt_tx_arb: randomized frames against a transaction-level model.
// Round-robin order is modelled as a rotating queue of requester ids.
module tb_lv_owt_tx_arb;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int TH  = 20;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arb_en = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  ack;
    logic          tx_vld;
    logic          tx_rdy = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_done = 1'b0;
    logic          tmo_err;
    logic [1:0]    grant_id;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    int rr_q[$];
    int win;

    lv_owt_tx_arb #(
        .REQ_NUM (N),
        .TX_DW   (DW),
        .TMO_W   (10),
        .TMO_TH  (TH),
        .GAP_CYC (GAP)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_arb_en   (arb_en),
        .i_req      (req),
        .i_req_data (req_data),
        .o_ack      (ack),
        .o_tx_vld   (tx_vld),
        .i_tx_rdy   (tx_rdy),
        .o_tx_data  (tx_data),
        .i_tx_done  (tx_done),
        .o_tmo_err  (tmo_err),
        .o_grant_id (grant_id),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] rnd_pay();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic int model_pick(input logic [N-1:0] r);
        if (r[0]) return 0;
        foreach (rr_q[i]) if (r[rr_q[i]]) return rr_q[i];
        return 0;
    endfunction

    function automatic void model_ack(input int k);
        if (k == 0) return;
        while (rr_q[0] != k) rr_q.push_back(rr_q.pop_front());
        rr_q.push_back(rr_q.pop_front());
    endfunction

    task automatic run_frame(input int rw, input int d,
                             input logic [N*DW-1:0] pay, output int w);
        logic [DW-1:0] exp_data;
        int ack_k;
        w = model_pick(req);
        req_data = pay;
        exp_data = pay[w*DW +: DW];
        tick;
        check("grant_vld", 32'(tx_vld), 1);
        check("grant_busy", 32'(busy), 1);
        check("grant_id", 32'(grant_id), 32'(w));
        check("grant_data", 32'(tx_data), 32'(exp_data));
        req_data = rnd_pay();
        tx_rdy = 1'b0;
        for (int i = 0; i < rw; i++) begin
            tx_done = 1'($urandom);
            tick;
            check("bp_vld", 32'(tx_vld), 1);
            check("bp_data", 32'(tx_data), 32'(exp_data));
        end
        tx_done = 1'b0;
        tx_rdy = 1'b1;
        tick;
        tx_rdy = 1'b0;
        check("acc_vld", 32'(tx_vld), 0);
        ack_k = (d <= TH) ? d : TH;
        for (int k = 1; k <= ack_k; k++) begin
            tx_done = (k == d);
            tick;
            check("ack", 32'(ack), (k == ack_k) ? (32'(1) << w) : 0);
            check("tmo_err", 32'(tmo_err), 32'(k == ack_k && d > TH));
        end
        tx_done = 1'b0;
        req[w] = 1'b0;
        model_ack(w);
        for (int g = 1; g < GAP; g++) begin
            tx_done = 1'($urandom);
            tick;
            check("gap_busy", 32'(busy), 1);
            check("gap_ack", 32'(ack), 0);
        end
        tx_done = 1'b0;
        tick;
        check("idle_busy", 32'(busy), 0);
        check("idle_vld", 32'(tx_vld), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_vld"}, 32'(tx_vld), 0);
        check({tag, "_data"}, 32'(tx_data), 0);
        check({tag, "_err"}, 32'(tmo_err), 0);
        check({tag, "_gid"}, 32'(grant_id), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic [DW-1:0] fl_data;
        int r;
        int dd;
        rr_q = {1, 2};
        #2;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;
        arb_en = 1'b1;
        tick;

        req = 3'b010;
        run_frame(0, 5, {16'h1111, 16'hA5C3, 16'h2222}, win);

        req = 3'b111;
        repeat (3) run_frame(0, 2, rnd_pay(), win);
        repeat (2) begin
            req = 3'b110;
            repeat (2) run_frame(0, 2, rnd_pay(), win);
        end

        req = 3'b001;
        run_frame(7, 3, rnd_pay(), win);

        req = 3'b100;
        run_frame(0, 1000, rnd_pay(), win);
        req = 3'b010;
        run_frame(2, TH, rnd_pay(), win);

        req = 3'b100;
        req_data = rnd_pay();
        fl_data = req_data[2*DW +: DW];
        tick;
        check("fl_gid", 32'(grant_id), 2);
        tx_rdy = 1'b1;
        tick;
        tx_rdy = 1'b0;
        repeat (3) tick;
        arb_en = 1'b0;
        tick;
        check("fl_busy", 32'(busy), 0);
        check("fl_vld", 32'(tx_vld), 0);
        check("fl_ack", 32'(ack), 0);
        check("fl_err", 32'(tmo_err), 0);
        check("fl_gid_hold", 32'(grant_id), 2);
        check("fl_data_hold", 32'(tx_data), 32'(fl_data));
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        tick;
        check("late_ack", 32'(ack), 0);
        check("late_err", 32'(tmo_err), 0);
        check("late_busy", 32'(busy), 0);
        arb_en = 1'b1;
        run_frame(1, 4, rnd_pay(), win);

        req = 3'b010;
        run_frame(0, 2, rnd_pay(), win);
        req = 3'b110;
        req_data = rnd_pay();
        tick;
        check("pre_rst_gid", 32'(grant_id), 32'(model_pick(req)));
        check("pre_rst_vld", 32'(tx_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        req = '0;
        rr_q = {1, 2};
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        req = 3'b110;
        run_frame(0, 3, rnd_pay(), win);

        for (int f = 0; f < 30; f++) begin
            req = req | N'($urandom);
            if (req == '0) req = 3'b010;
            r = $urandom_range(0, 9);
            if (r < 6) dd = $urandom_range(1, TH - 1);
            else if (r < 8) dd = TH;
            else dd = TH + 1 + $urandom_range(0, 5);
            run_frame($urandom_range(0, 4), dd, rnd_pay(), win);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
